secuenciador_compuertas: RTL and testbench

//  Self-test sequencer placed directly upstream of the 3-input logic-gate selector (compuertasLogicas).

---
 rtl/compuertas_pkg.sv | 39 +++
 rtl/secuenciador_compuertas_if.sv | 32 +++
 rtl/secuenciador_compuertas.sv | 159 +++++++++++++++
 tb/tb_secuenciador_compuertas.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/compuertas_pkg.sv
// Shared definitions for the gate-block self-test sequencer: function-select
// codes, FSM state encoding and the golden model of the 3-input gate selector.
package compuertas_pkg;

  localparam logic [2:0] SEL_AND  = 3'b001;
  localparam logic [2:0] SEL_OR   = 3'b010;
  localparam logic [2:0] SEL_XOR  = 3'b011;
  localparam logic [2:0] SEL_NAND = 3'b100;
  localparam logic [2:0] SEL_NOR  = 3'b101;
  localparam logic [2:0] SEL_XNOR = 3'b110;

  // Number of vectors in one sweep: 3 select bits plus 3 operand bits.
  localparam int unsigned NUM_VEC = 64;

  typedef enum logic [2:0] {
    StReposo,
    StAplica,
    StEspera,
    StCompara,
    StFin
  } estado_e;

  // Expected gate output; unused select codes (000/111) read as 0.
  function automatic logic modelo_compuerta(input logic [2:0] sel, input logic e1,
                                            input logic e2, input logic e3);
    logic y;
    case (sel)
      SEL_AND:  y = e1 & e2 & e3;
      SEL_OR:   y = e1 | e2 | e3;
      SEL_XOR:  y = e1 ^ e2 ^ e3;
      SEL_NAND: y = ~(e1 & e2 & e3);
      SEL_NOR:  y = ~(e1 | e2 | e3);
      SEL_XNOR: y = ~(e1 ^ e2 ^ e3);
      default:  y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/secuenciador_compuertas_if.sv
// Bundle between the self-test sequencer and the gate block plus its control
// and result signals. master = sequencer side, slave = gate block / host side.
interface secuenciador_compuertas_if #(
  parameter int unsigned ERR_W = 7
);
  logic             inicio;
  logic             ent1;
  logic             ent2;
  logic             ent3;
  logic             act;
  logic [2:0]       sel;
  logic             sal_dut;
  logic             ocupado;
  logic             fin;
  logic             error;
  logic [ERR_W-1:0] cuenta_errores;
  logic             fallo_valido;
  logic [2:0]       fallo_sel;
  logic [2:0]       fallo_ent;

  modport master (
    input  inicio, sal_dut,
    output ent1, ent2, ent3, act, sel, ocupado, fin, error, cuenta_errores,
           fallo_valido, fallo_sel, fallo_ent
  );

  modport slave (
    output inicio, sal_dut,
    input  ent1, ent2, ent3, act, sel, ocupado, fin, error, cuenta_errores,
           fallo_valido, fallo_sel, fallo_ent
  );
endinterface

// File: rtl/secuenciador_compuertas.sv
// Self-test sequencer for the 3-input gate selector. Walks all 64 {sel,ent}
// vectors, waits T_ESTAB cycles for the gate output to settle, compares it with
// the golden model and records error count and first failing vector.
module secuenciador_compuertas
  import compuertas_pkg::*;
#(
  parameter int unsigned T_ESTAB     = 2,
  parameter int unsigned ERR_W       = 7,
  parameter bit          MODO_PARADA = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  secuenciador_compuertas_if.master bus_io
);

  // Wait counter must hold T_ESTAB-1; keep at least one bit when T_ESTAB is 1.
  localparam int unsigned CntW = (T_ESTAB > 1) ? $clog2(T_ESTAB) : 1;
  localparam logic [CntW-1:0] EsperaCarga = CntW'(T_ESTAB - 1);
  localparam logic [5:0] IdxUltimo = 6'(NUM_VEC - 1);

  estado_e          estado_q, estado_d;
  logic [5:0]       idx_q, idx_d;
  logic [CntW-1:0]  espera_q, espera_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       ent_q, ent_d;
  logic             act_q, act_d;
  logic             error_q, error_d;
  logic [ERR_W-1:0] cuenta_q, cuenta_d;
  logic             fvalido_q, fvalido_d;
  logic [2:0]       fsel_q, fsel_d;
  logic [2:0]       fent_q, fent_d;
  logic             discrepa;

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q  <= StReposo;
      idx_q     <= '0;
      espera_q  <= '0;
      sel_q     <= '0;
      ent_q     <= '0;
      act_q     <= 1'b0;
      error_q   <= 1'b0;
      cuenta_q  <= '0;
      fvalido_q <= 1'b0;
      fsel_q    <= '0;
      fent_q    <= '0;
    end else begin
      estado_q  <= estado_d;
      idx_q     <= idx_d;
      espera_q  <= espera_d;
      sel_q     <= sel_d;
      ent_q     <= ent_d;
      act_q     <= act_d;
      error_q   <= error_d;
      cuenta_q  <= cuenta_d;
      fvalido_q <= fvalido_d;
      fsel_q    <= fsel_d;
      fent_q    <= fent_d;
    end
  end

  // Next-state logic: sweep sequencing, settling wait and result capture.
  always_comb begin
    estado_d  = estado_q;
    idx_d     = idx_q;
    espera_d  = espera_q;
    sel_d     = sel_q;
    ent_d     = ent_q;
    act_d     = act_q;
    error_d   = error_q;
    cuenta_d  = cuenta_q;
    fvalido_d = fvalido_q;
    fsel_d    = fsel_q;
    fent_d    = fent_q;
    discrepa  = 1'b0;

    unique case (estado_q)
      StReposo: begin
        act_d = 1'b0;
        if (bus_io.inicio) begin
          error_d   = 1'b0;
          cuenta_d  = '0;
          fvalido_d = 1'b0;
          fsel_d    = '0;
          fent_d    = '0;
          idx_d     = '0;
          estado_d  = StAplica;
        end
      end

      StAplica: begin
        sel_d    = idx_q[5:3];
        ent_d    = idx_q[2:0];
        act_d    = 1'b1;
        espera_d = EsperaCarga;
        estado_d = StEspera;
      end

      StEspera: begin
        if (espera_q == '0) begin
          estado_d = StCompara;
        end else begin
          espera_d = espera_q - 1'b1;
        end
      end

      StCompara: begin
        // sel_q/ent_q are the vector currently presented to the gate block.
        discrepa = bus_io.sal_dut != modelo_compuerta(sel_q, ent_q[2], ent_q[1], ent_q[0]);
        if (discrepa) begin
          error_d = 1'b1;
          if (cuenta_q != {ERR_W{1'b1}}) begin
            cuenta_d = cuenta_q + 1'b1;
          end
          if (!fvalido_q) begin
            fvalido_d = 1'b1;
            fsel_d    = sel_q;
            fent_d    = ent_q;
          end
        end
        if (idx_q == IdxUltimo || (MODO_PARADA && discrepa)) begin
          act_d    = 1'b0;
          estado_d = StFin;
        end else begin
          idx_d    = idx_q + 6'd1;
          estado_d = StAplica;
        end
      end

      StFin: begin
        act_d    = 1'b0;
        estado_d = StReposo;
      end

      default: begin
        act_d    = 1'b0;
        estado_d = StReposo;
      end
    endcase
  end

  // Output drive: registered gate stimulus, status decoded from state.
  always_comb begin
    bus_io.ent1           = ent_q[2];
    bus_io.ent2           = ent_q[1];
    bus_io.ent3           = ent_q[0];
    bus_io.sel            = sel_q;
    bus_io.act            = act_q;
    bus_io.ocupado        = estado_q != StReposo;
    bus_io.fin            = estado_q == StFin;
    bus_io.error          = error_q;
    bus_io.cuenta_errores = cuenta_q;
    bus_io.fallo_valido   = fvalido_q;
    bus_io.fallo_sel      = fsel_q;
    bus_io.fallo_ent      = fent_q;
  end

endmodule

// File: tb/tb_secuenciador_compuertas.sv
// Bench for secuenciador_compuertas: three instances (default, stop-on-first
// mismatch, 4-bit error counter) sharing clock and reset, a fake gate block
// with selectable faults, and an independent reference model of the sweep.
module tb_secuenciador_compuertas;

  localparam int VecCyc  = 4;  // T_ESTAB + 2 cycles per vector
  localparam int FullCyc = 64 * VecCyc + 1;

  typedef struct {
    int         mode;   // 0 good, 1 stuck 0, 2 stuck 1, 3 good ^ mask
    int         cnt;
    bit         err;
    bit         fv;
    logic [2:0] fsel;
    logic [2:0] fent;
    int         cycles;
    int         last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  ini = '0;
  int          mode = 0;
  logic [63:0] mask = '0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  // Reference gate from the truth-table rules: count of ones among the inputs.
  function automatic logic ref_gate(input logic [5:0] v);
    int n;
    n = int'(v[0]) + int'(v[1]) + int'(v[2]);
    case (v[5:3])
      3'd1:    return n == 3;
      3'd2:    return n != 0;
      3'd3:    return (n % 2) == 1;
      3'd4:    return n != 3;
      3'd5:    return n == 0;
      3'd6:    return (n % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic fake_gate(input int m, input logic [63:0] mk, input logic [5:0] v);
    case (m)
      0:       return ref_gate(v);
      1:       return 1'b0;
      2:       return 1'b1;
      default: return ref_gate(v) ^ mk[v];
    endcase
  endfunction

  secuenciador_compuertas_if #(.ERR_W(7)) if_a ();
  secuenciador_compuertas_if #(.ERR_W(7)) if_p ();
  secuenciador_compuertas_if #(.ERR_W(4)) if_s ();

  secuenciador_compuertas #(.T_ESTAB(2), .ERR_W(7), .MODO_PARADA(1'b0)) u_a (
    .clk(clk), .reset(reset), .bus_io(if_a.master));
  secuenciador_compuertas #(.T_ESTAB(2), .ERR_W(7), .MODO_PARADA(1'b1)) u_p (
    .clk(clk), .reset(reset), .bus_io(if_p.master));
  secuenciador_compuertas #(.T_ESTAB(2), .ERR_W(4), .MODO_PARADA(1'b0)) u_s (
    .clk(clk), .reset(reset), .bus_io(if_s.master));

  assign if_a.inicio = ini[0];
  assign if_p.inicio = ini[1];
  assign if_s.inicio = ini[2];
  assign if_a.sal_dut = fake_gate(mode, mask, {if_a.sel, if_a.ent1, if_a.ent2, if_a.ent3});
  assign if_p.sal_dut = fake_gate(mode, mask, {if_p.sel, if_p.ent1, if_p.ent2, if_p.ent3});
  assign if_s.sal_dut = fake_gate(mode, mask, {if_s.sel, if_s.ent1, if_s.ent2, if_s.ent3});

  // Per-instance views so one sweep task serves all three.
  logic [31:0] cnt_w  [3];
  logic [5:0]  vec_w  [3];
  logic [2:0]  fsel_w [3];
  logic [2:0]  fent_w [3];
  logic        ocup_w [3];
  logic        fin_w  [3];
  logic        act_w  [3];
  logic        err_w  [3];
  logic        fv_w   [3];

  assign cnt_w[0]  = 32'(if_a.cuenta_errores);
  assign cnt_w[1]  = 32'(if_p.cuenta_errores);
  assign cnt_w[2]  = 32'(if_s.cuenta_errores);
  assign vec_w[0]  = {if_a.sel, if_a.ent1, if_a.ent2, if_a.ent3};
  assign vec_w[1]  = {if_p.sel, if_p.ent1, if_p.ent2, if_p.ent3};
  assign vec_w[2]  = {if_s.sel, if_s.ent1, if_s.ent2, if_s.ent3};
  assign fsel_w[0] = if_a.fallo_sel;
  assign fsel_w[1] = if_p.fallo_sel;
  assign fsel_w[2] = if_s.fallo_sel;
  assign fent_w[0] = if_a.fallo_ent;
  assign fent_w[1] = if_p.fallo_ent;
  assign fent_w[2] = if_s.fallo_ent;
  assign ocup_w[0] = if_a.ocupado;
  assign ocup_w[1] = if_p.ocupado;
  assign ocup_w[2] = if_s.ocupado;
  assign fin_w[0]  = if_a.fin;
  assign fin_w[1]  = if_p.fin;
  assign fin_w[2]  = if_s.fin;
  assign act_w[0]  = if_a.act;
  assign act_w[1]  = if_p.act;
  assign act_w[2]  = if_s.act;
  assign err_w[0]  = if_a.error;
  assign err_w[1]  = if_p.error;
  assign err_w[2]  = if_s.error;
  assign fv_w[0]   = if_a.fallo_valido;
  assign fv_w[1]   = if_p.fallo_valido;
  assign fv_w[2]   = if_s.fallo_valido;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  // Expected sweep outcome from the list of mismatching vectors.
  task automatic model(input int m, input logic [63:0] mk, input bit stop, input int errw,
                       output exp_t e);
    int         sum;
    int         first;
    int         sat;
    logic [5:0] v;
    sum   = 0;
    first = -1;
    sat   = (1 << errw) - 1;
    for (int i = 0; i < 64; i++) begin
      if (!(stop && first >= 0)) begin
        v = 6'(i);
        if (fake_gate(m, mk, v) != ref_gate(v)) begin
          sum++;
          if (first < 0) first = i;
        end
      end
    end
    e.mode   = m;
    e.cnt    = (sum > sat) ? sat : sum;
    e.err    = sum > 0;
    e.fv     = sum > 0;
    e.fsel   = (first >= 0) ? 3'(first / 8) : 3'd0;
    e.fent   = (first >= 0) ? 3'(first % 8) : 3'd0;
    e.cycles = (stop && first >= 0) ? VecCyc * (first + 1) + 1 : FullCyc;
    e.last   = (stop && first >= 0) ? first : 63;
  endtask

  // Pulse inicio, then watch until ocupado drops (bounded).
  task automatic run_sweep(input int w, input bit rep, output int cyc, output int fin_at,
                           output int fins, output int lastv, output bit ord_ok,
                           output bit act_ok);
    int bound;
    cyc = 0; fin_at = 0; fins = 0; lastv = 0; ord_ok = 1'b1; act_ok = 1'b1; bound = 0;
    @(negedge clk);
    ini[w] = 1'b1;
    @(negedge clk);
    ini[w] = 1'b0;
    while (ocup_w[w] && bound < 2000) begin
      cyc++;
      if (fin_w[w]) begin
        fins++;
        fin_at = cyc;
        if (act_w[w]) act_ok = 1'b0;
      end
      if (act_w[w]) begin
        if (int'(vec_w[w]) == lastv + 1) lastv++;
        else if (int'(vec_w[w]) != lastv) ord_ok = 1'b0;
      end
      ini[w] = rep && (cyc == 10 || cyc == 100);
      @(negedge clk);
      bound++;
    end
    ini[w] = 1'b0;
  endtask

  task automatic verify(input int w, input exp_t e, input bit rep, input string tag);
    int cyc, fat, fins, lastv;
    bit ook, aok;
    mode = e.mode;
    run_sweep(w, rep, cyc, fat, fins, lastv, ook, aok);
    chk({tag, ".cycles"}, cyc, e.cycles);
    chk({tag, ".fin_at"}, fat, e.cycles);
    chk({tag, ".fin_pulses"}, fins, 1);
    chk({tag, ".cuenta"}, cnt_w[w], e.cnt);
    chk({tag, ".error"}, err_w[w], e.err);
    chk({tag, ".fallo_valido"}, fv_w[w], e.fv);
    chk({tag, ".fallo_sel"}, fsel_w[w], e.fsel);
    chk({tag, ".fallo_ent"}, fent_w[w], e.fent);
    chk({tag, ".last_vec"}, lastv, e.last);
    chk({tag, ".vec_order"}, ook, 1);
    chk({tag, ".act_low_in_fin"}, aok, 1);
    repeat (3) @(negedge clk);
    chk({tag, ".hold_cuenta"}, cnt_w[w], e.cnt);
    chk({tag, ".idle_after"}, ocup_w[w], 0);
  endtask

  exp_t tabla [3];
  exp_t e;

  initial begin
    int bound;
    tabla[0] = '{mode: 0, cnt: 0,  err: 0, fv: 0, fsel: 3'd0, fent: 3'd0, cycles: FullCyc,
                 last: 63};
    tabla[1] = '{mode: 1, cnt: 24, err: 1, fv: 1, fsel: 3'd1, fent: 3'd7, cycles: FullCyc,
                 last: 63};
    tabla[2] = '{mode: 2, cnt: 40, err: 1, fv: 1, fsel: 3'd0, fent: 3'd0, cycles: FullCyc,
                 last: 63};

    // Reset state.
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.outputs_a", 32'({if_a.ent1, if_a.ent2, if_a.ent3, if_a.act, if_a.sel,
        if_a.ocupado, if_a.fin, if_a.error, if_a.cuenta_errores, if_a.fallo_valido,
        if_a.fallo_sel, if_a.fallo_ent}), 0);
    chk("reset.ocupado_p", ocup_w[1], 0);
    @(negedge clk);
    reset = 1'b0;

    // Fixed gate behaviours on the default instance.
    for (int i = 0; i < 3; i++) begin
      verify(0, tabla[i], 1'b0, $sformatf("tabla%0d", i));
    end

    // Stop-on-first-mismatch with output stuck at 0: stops on vector 15.
    e = '{mode: 1, cnt: 1, err: 1, fv: 1, fsel: 3'd1, fent: 3'd7, cycles: 65, last: 15};
    verify(1, e, 1'b0, "parada_stuck0");

    // 4-bit counter saturates; inicio re-pulsed mid-sweep must be ignored.
    e = '{mode: 2, cnt: 15, err: 1, fv: 1, fsel: 3'd0, fent: 3'd0, cycles: FullCyc, last: 63};
    verify(2, e, 1'b1, "satura_repulso");

    // Reset in the middle of vector 30, with errors already recorded.
    mode = 1;
    @(negedge clk);
    ini[0] = 1'b1;
    @(negedge clk);
    ini[0] = 1'b0;
    bound = 0;
    while (!(if_a.act && vec_w[0] == 6'd30) && bound < 1000) begin
      @(negedge clk);
      bound++;
    end
    chk("reset_mid.reached_vec30", vec_w[0], 30);
    chk("reset_mid.error_before", err_w[0], 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("reset_mid.outputs_zero", 32'({if_a.ent1, if_a.ent2, if_a.ent3, if_a.act, if_a.sel,
        if_a.ocupado, if_a.fin, if_a.error, if_a.cuenta_errores, if_a.fallo_valido,
        if_a.fallo_sel, if_a.fallo_ent}), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_mid.stays_idle", ocup_w[0], 0);
    verify(0, tabla[0], 1'b0, "tras_reset");

    // Randomised fault masks against the reference model.
    for (int r = 0; r < 6; r++) begin
      mask = {$urandom, $urandom};
      if (r % 2 == 1) mask = mask & {$urandom, $urandom} & {$urandom, $urandom};
      if (r == 5) mask = 64'd1 << $urandom_range(63, 0);
      model(3, mask, 1'b0, 7, e);
      verify(0, e, 1'b0, $sformatf("rand_a%0d", r));
      model(3, mask, 1'b1, 7, e);
      verify(1, e, 1'b0, $sformatf("rand_p%0d", r));
      if (r < 2) begin
        model(3, mask, 1'b0, 4, e);
        verify(2, e, 1'b0, $sformatf("rand_s%0d", r));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
